mul_ctrl: RTL and testbench
===========================

Name: mul_ctrl

Overview:
- Multi-cycle multiply sequencer that sits beside the execute stage.
- Accepts a multiply issued from decode (MULOp with Rs/Rt operands) and runs an iterative shift-add multiply over WIDTH/STEP cycles.
- Writes the 2*WIDTH product into HI/LO registers.
- Raises Busy so the pipeline's hazard logic stalls any HI/LO read until the result is committed.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits.
STEP, 1, multiplier bits retired per cycle. Legal values are 1, 2 or 4, and STEP must divide WIDTH.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Start  input  1  single-cycle issue pulse for a multiply
Signed  input  1  operands are two's complement (MULT); 0 means unsigned (MULTU)
Flush  input  1  abort the in-flight multiply; HI/LO are not updated
RsData  input  WIDTH  multiplicand
RtData  input  WIDTH  multiplier
Busy  output  1  high in states RUN and FIX
Done  output  1  one-cycle pulse; HI/LO were updated at the preceding edge
HI  output  WIDTH  upper product half, held until the next completion
LO  output  WIDTH  lower product half, held until the next completion

Behaviour:
- Reset, asynchronous:
  - state=IDLE; HI=0, LO=0; Busy=0, Done=0.
  - Accumulator, counter and operand registers cleared.
  - Reset asserted mid-operation aborts immediately; outputs take reset values.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE, with Start=1 sampled at edge E0:
  - Latch |RsData| and |RtData| (absolute values only when Signed=1; otherwise raw).
  - Latch neg = Signed & (Rs[MSB] ^ Rt[MSB]).
  - Clear the 2*WIDTH accumulator; load counter = WIDTH/STEP; go to RUN.
- RUN, per edge:
  - Add multiplicand * (STEP low bits of the multiplier) into the accumulator's upper half.
  - Shift the accumulator/multiplier right by STEP; decrement the counter.
  - When the counter reaches 0, go to FIX. RUN lasts exactly WIDTH/STEP edges.
- FIX: one edge. Product = neg ? (two's-complement negation over 2*WIDTH bits) : accumulator. Write {HI,LO}; go to DONE.
- DONE: Done=1 for this cycle only.
  - Start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise return to IDLE.
- Latency:
  - HI/LO written at edge E0+WIDTH/STEP+1; Done high in the following cycle (33 edges for 32/1).
  - Busy is high from the cycle after E0 through the FIX cycle.
- Arithmetic:
  - Unsigned magnitudes are handled at WIDTH+1 bits internally, so |0x80000000| = 0x80000000 is exact.
  - The negation step covers the full 2*WIDTH result. No overflow is possible.
- Start while Busy=1 is ignored; no queueing. The hazard unit is responsible for never issuing a second multiply while busy.
- Flush:
  - In RUN or FIX: go to IDLE at the next edge; HI/LO unchanged; Done stays 0.
  - Flush and Start in the same IDLE/DONE cycle: Flush wins and the Start is dropped.
  - Flush in IDLE/DONE without Start: no effect apart from DONE → IDLE.
- RsData/RtData/Signed are sampled only at the accepting edge. Later changes do not affect the operation.
- HI/LO change only at the FIX edge or on reset.

Test Plan:
- Reset, then Start with Signed=0, Rs=7, Rt=6 → Busy high for 33 cycles (STEP=1); Done pulses at cycle 34; HI=0x00000000, LO=0x0000002A.
- Signed=1, Rs=0xFFFFFFFD (-3), Rt=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Signed=0, Rs=Rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then Signed=1 with the same operands → HI=0, LO=1.
- Signed=1, Rs=Rt=0x80000000 → HI=0x40000000, LO=0. Also Rs=0x80000000, Rt=1 → HI=0xFFFFFFFF, LO=0x80000000.
- Complete 3*3 (LO=9), then Start 2*2 and assert Flush at RUN cycle 10 → Busy drops the next cycle, no Done, LO stays 9. A second Start while Busy is ignored: the result equals the first operation's.
- Assert Reset mid-RUN → HI/LO/Busy/Done go to 0 immediately. Repeat the first scenario with STEP=4 → Done 10 cycles after Start.

Source files
------------

// File: rtl/mul_ctrl.sv
// Iterative shift-add multiply sequencer beside the execute stage.
// Retires STEP multiplier bits per cycle and commits the 2*WIDTH product to HI/LO.
module mul_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned NSTEP = WIDTH / STEP;
    localparam int unsigned CW    = $clog2(NSTEP + 1);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned SW    = WIDTH + STEP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_n;

    logic             load, step, commit;
    logic [WIDTH-1:0] mcand, mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             neg;

    logic [WIDTH:0]   rs_ext, rt_ext, rs_abs, rt_abs;
    logic             neg_in;
    logic [SW-1:0]    sum;
    logic [PW-1:0]    prod;

    // Magnitudes are formed at WIDTH+1 bits so the most negative operand stays exact.
    always_comb begin
        rs_ext = {signed_op & rs_data[WIDTH-1], rs_data};
        rt_ext = {signed_op & rt_data[WIDTH-1], rt_data};
        rs_abs = rs_ext[WIDTH] ? -rs_ext : rs_ext;
        rt_abs = rt_ext[WIDTH] ? -rt_ext : rt_ext;
        neg_in = signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
    end

    // One partial product into the upper half; the max sum fits in WIDTH+STEP bits.
    always_comb begin
        sum  = SW'(acc[PW-1:WIDTH]) + SW'(mcand) * SW'(mplier[STEP-1:0]);
        prod = neg ? -acc : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start && !flush) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_n = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CW'(1)) begin
                        state_n = FIX;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_n = IDLE;
                end else begin
                    commit  = 1'b1;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_n == RUN) || (state_n == FIX);
            done <= (state_n == DONE);
            if (load) begin
                mcand  <= WIDTH'(rs_abs);
                mplier <= WIDTH'(rt_abs);
                neg    <= neg_in;
                acc    <= '0;
                cnt    <= CW'(NSTEP);
            end
            if (step) begin
                acc    <= {sum, acc[WIDTH-1:STEP]};
                mplier <= mplier >> STEP;
                cnt    <= cnt - CW'(1);
            end
            if (commit) begin
                {hi, lo} <= prod;
            end
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed self-checking bench for mul_ctrl: a STEP=1 instance and a STEP=4 instance.
module tb_mul_ctrl;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start1, start4, signed_op, flush;
    logic [W-1:0] rs, rt;
    logic         busy1, done1, busy4, done4;
    logic [W-1:0] hi1, lo1, hi4, lo4;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mul_ctrl #(.WIDTH(W), .STEP(1)) dut (
        .clk(clk), .rst(rst), .start(start1), .signed_op(signed_op), .flush(flush),
        .rs_data(rs), .rt_data(rt), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    mul_ctrl #(.WIDTH(W), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_op(signed_op), .flush(flush),
        .rs_data(rs), .rt_data(rt), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for done, counting edges and busy cycles along the way.
    task automatic wait_done(input bit use4, output int edges, output int busy_n);
        edges  = 0;
        busy_n = 0;
        while (edges < 100) begin
            if (use4 ? done4 : done1) break;
            if (use4 ? busy4 : busy1) busy_n++;
            tick;
            edges++;
        end
    endtask

    // Issues one multiply, then scrambles the operand inputs to show they are not re-sampled.
    task automatic do_mul(input bit use4, input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int edges, output int busy_n);
        signed_op = s;
        rs        = a;
        rt        = b;
        if (use4) start4 = 1'b1;
        else      start1 = 1'b1;
        tick;
        start1    = 1'b0;
        start4    = 1'b0;
        rs        = ~a;
        rt        = ~b;
        signed_op = ~s;
        wait_done(use4, edges, busy_n);
    endtask

    initial begin
        int  edges, busy_n;
        bit  seen_done;

        rst = 1'b1; start1 = 1'b0; start4 = 1'b0; signed_op = 1'b0; flush = 1'b0;
        rs = '0; rt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", hi1, 0);
        chk("reset_lo", lo1, 0);
        chk("reset_busy", busy1, 0);
        chk("reset_done", done1, 0);
        rst = 1'b0;
        tick;

        // 7*6 unsigned: 33 busy cycles, done 33 edges after the accepting edge
        do_mul(0, 0, 32'd7, 32'd6, edges, busy_n);
        chk("u7x6_edges", 64'(edges), 33);
        chk("u7x6_busy", 64'(busy_n), 33);
        chk("u7x6_hi", hi1, 32'h0000_0000);
        chk("u7x6_lo", lo1, 32'h0000_002A);
        tick;
        chk("u7x6_done_pulse", done1, 0);
        chk("u7x6_lo_hold", lo1, 32'h0000_002A);

        do_mul(0, 1, 32'hFFFF_FFFD, 32'd5, edges, busy_n);
        chk("s_m3x5_hi", hi1, 32'hFFFF_FFFF);
        chk("s_m3x5_lo", lo1, 32'hFFFF_FFF1);

        // issued from DONE: back-to-back acceptance
        do_mul(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, busy_n);
        chk("b2b_edges", 64'(edges), 33);
        chk("u_ffxff_hi", hi1, 32'hFFFF_FFFE);
        chk("u_ffxff_lo", lo1, 32'h0000_0001);

        do_mul(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, busy_n);
        chk("s_m1xm1_hi", hi1, 32'h0000_0000);
        chk("s_m1xm1_lo", lo1, 32'h0000_0001);

        do_mul(0, 1, 32'h8000_0000, 32'h8000_0000, edges, busy_n);
        chk("s_min2_hi", hi1, 32'h4000_0000);
        chk("s_min2_lo", lo1, 32'h0000_0000);

        do_mul(0, 1, 32'h8000_0000, 32'd1, edges, busy_n);
        chk("s_minx1_hi", hi1, 32'hFFFF_FFFF);
        chk("s_minx1_lo", lo1, 32'h8000_0000);

        do_mul(0, 0, 32'd3, 32'd3, edges, busy_n);
        chk("u3x3_lo", lo1, 32'd9);

        // flush during RUN cycle 10 of a 2*2
        signed_op = 1'b0; rs = 32'd2; rt = 32'd2; start1 = 1'b1;
        tick;
        start1 = 1'b0;
        repeat (9) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_busy", busy1, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done1) seen_done = 1'b1;
            tick;
        end
        chk("flush_no_done", 64'(seen_done), 0);
        chk("flush_lo_kept", lo1, 32'd9);
        chk("flush_hi_kept", hi1, 32'd0);

        // flush and start together in IDLE: start dropped
        rs = 32'd1; rt = 32'd1; start1 = 1'b1; flush = 1'b1;
        tick;
        start1 = 1'b0; flush = 1'b0;
        chk("flush_start_drop", busy1, 0);

        // start while busy is ignored
        rs = 32'd5; rt = 32'd5; signed_op = 1'b0; start1 = 1'b1;
        tick;
        start1 = 1'b0; rs = 32'd7; rt = 32'd7;
        repeat (3) tick;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        wait_done(0, edges, busy_n);
        chk("busy_start_edges", 64'(edges + 4), 33);
        chk("busy_start_lo", lo1, 32'd25);

        // asynchronous reset mid-RUN
        rs = 32'd3; rt = 32'd4; start1 = 1'b1;
        tick;
        start1 = 1'b0;
        repeat (5) tick;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy1, 0);
        chk("arst_done", done1, 0);
        chk("arst_hi", hi1, 0);
        chk("arst_lo", lo1, 0);
        rst = 1'b0;
        tick;

        // STEP=4: 8 RUN edges + FIX, done visible 9 edges after the accepting edge
        do_mul(1, 0, 32'd7, 32'd6, edges, busy_n);
        chk("s4_u7x6_edges", 64'(edges), 9);
        chk("s4_u7x6_busy", 64'(busy_n), 9);
        chk("s4_u7x6_hi", hi4, 32'h0000_0000);
        chk("s4_u7x6_lo", lo4, 32'h0000_002A);

        do_mul(1, 1, 32'hFFFF_FFFD, 32'd5, edges, busy_n);
        chk("s4_m3x5_hi", hi4, 32'hFFFF_FFFF);
        chk("s4_m3x5_lo", lo4, 32'hFFFF_FFF1);

        do_mul(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, busy_n);
        chk("s4_ffxff_hi", hi4, 32'hFFFF_FFFE);
        chk("s4_ffxff_lo", lo4, 32'h0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
